// File: rtl/pic_inta_master.sv
// -----------------------------------------------------------------------------
// pic_inta_master
//
// CPU-side interrupt acknowledge sequencer for an 8259-style PIC. When the PIC
// raises INT, the block runs an 8086-style two-pulse INTA cycle. It captures
// the vector the PIC drives during the second pulse and waits a programmable
// service time. It then writes a non-specific EOI (OCW2) so the PIC can clear
// its in-service bit.
//
// Ports:
//   clock        : system clock, rising edge
//   reset_n      : asynchronous active-low reset
//   enable       : permits a new acknowledge sequence (sampled in IDLE only)
//   int_req      : INT from the PIC (sampled in IDLE only)
//   data_in[7:0] : PIC data bus, captured on the edge that ends INTA2
//   inta_n       : interrupt acknowledge, active low
//   cs_n, wr_n   : PIC chip select / write strobe for the EOI write, active low
//   a0           : PIC address line, always 0 (OCW2)
//   data_out[7:0]: write data, 0 whenever data_oe is low
//   data_oe      : data_out drive enable
//   vector[7:0]  : last captured vector, held until the next capture
//   vector_valid : one-cycle pulse in the first SERVICE cycle
//   eoi_done     : one-cycle pulse in the EOI recovery cycle
//   busy         : high whenever the sequencer is not idle
//   state_dbg    : current FSM state encoding
//
// Handshake: there is no valid/ready pair here. int_req/enable act as a
// level-sensitive request seen only in IDLE. Once taken, the sequence always
// runs to completion (including the EOI) unless reset_n is asserted.
// -----------------------------------------------------------------------------
module pic_inta_master #(
  parameter int         INTA_LOW_CYCLES = 2,
  parameter int         INTA_GAP_CYCLES = 2,
  parameter int         SERVICE_CYCLES  = 4,
  parameter logic [7:0] EOI_CMD         = 8'h20
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       int_req,
  input  logic [7:0] data_in,
  output logic       inta_n,
  output logic       cs_n,
  output logic       wr_n,
  output logic       a0,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic [7:0] vector,
  output logic       vector_valid,
  output logic       eoi_done,
  output logic       busy,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INTA1   = 3'd1,
    S_GAP     = 3'd2,
    S_INTA2   = 3'd3,
    S_SERVICE = 3'd4,
    S_EOI_WR  = 3'd5,
    S_EOI_REC = 3'd6
  } state_t;

  localparam int MAX_LG = (INTA_LOW_CYCLES > INTA_GAP_CYCLES) ? INTA_LOW_CYCLES : INTA_GAP_CYCLES;
  localparam int MAX_P  = (MAX_LG > SERVICE_CYCLES) ? MAX_LG : SERVICE_CYCLES;
  localparam int CW     = $clog2(MAX_P) + 1;

  // The shared counter is loaded with N-1 on state entry and the state
  // advances when it reaches zero, so each timed state lasts exactly N clocks.
  localparam logic [CW-1:0] LOW_LOAD = CW'(INTA_LOW_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD = CW'(INTA_GAP_CYCLES - 1);
  localparam logic [CW-1:0] SRV_LOAD = CW'(SERVICE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    vector_q, vector_d;
  logic          vector_valid_q, vector_valid_d;
  logic          inta_n_q, inta_n_d;
  logic          cs_n_q, cs_n_d;
  logic          wr_n_q, wr_n_d;
  logic [7:0]    data_out_q, data_out_d;
  logic          data_oe_q, data_oe_d;
  logic          eoi_done_q, eoi_done_d;
  logic          busy_q, busy_d;
  logic          cnt_zero;
  logic          eoi_wr_next;

  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    vector_d       = vector_q;
    vector_valid_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (enable && int_req) begin
          state_d = S_INTA1;
          cnt_d   = LOW_LOAD;
        end
      end
      S_INTA1: begin
        if (cnt_zero) begin
          state_d = S_GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_GAP: begin
        if (cnt_zero) begin
          state_d = S_INTA2;
          cnt_d   = LOW_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_INTA2: begin
        // Only the value present on the edge leaving INTA2 is taken.
        if (cnt_zero) begin
          state_d        = S_SERVICE;
          cnt_d          = SRV_LOAD;
          vector_d       = data_in;
          vector_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_SERVICE: begin
        if (cnt_zero) begin
          state_d = S_EOI_WR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_EOI_WR:  state_d = S_EOI_REC;
      S_EOI_REC: state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are decoded from the next state and registered, so they line
    // up with the state they belong to without combinational glitches.
    eoi_wr_next = (state_d == S_EOI_WR);
    inta_n_d    = !((state_d == S_INTA1) || (state_d == S_INTA2));
    cs_n_d      = !eoi_wr_next;
    wr_n_d      = !eoi_wr_next;
    data_oe_d   = eoi_wr_next;
    data_out_d  = eoi_wr_next ? EOI_CMD : 8'h00;
    eoi_done_d  = (state_d == S_EOI_REC);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      vector_q       <= 8'h00;
      vector_valid_q <= 1'b0;
      inta_n_q       <= 1'b1;
      cs_n_q         <= 1'b1;
      wr_n_q         <= 1'b1;
      data_out_q     <= 8'h00;
      data_oe_q      <= 1'b0;
      eoi_done_q     <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      vector_q       <= vector_d;
      vector_valid_q <= vector_valid_d;
      inta_n_q       <= inta_n_d;
      cs_n_q         <= cs_n_d;
      wr_n_q         <= wr_n_d;
      data_out_q     <= data_out_d;
      data_oe_q      <= data_oe_d;
      eoi_done_q     <= eoi_done_d;
      busy_q         <= busy_d;
    end
  end

  assign inta_n       = inta_n_q;
  assign cs_n         = cs_n_q;
  assign wr_n         = wr_n_q;
  assign a0           = 1'b0;
  assign data_out     = data_out_q;
  assign data_oe      = data_oe_q;
  assign vector       = vector_q;
  assign vector_valid = vector_valid_q;
  assign eoi_done     = eoi_done_q;
  assign busy         = busy_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_pic_inta_master.sv
// -----------------------------------------------------------------------------
// tb_pic_inta_master
//
// Two instances: dut0 with default timing and dut1 with every timing parameter
// at 1. Each is compared cycle by cycle against a timeline model. The model
// keeps only "cycles since the sampling edge" and derives every output from
// the L/G/S cycle formulas. Captured vectors of dut0 also go through an
// expected queue that is drained on each vector_valid pulse.
// -----------------------------------------------------------------------------
module tb_pic_inta_master;

  localparam int L0 = 2, G0 = 2, S0 = 4;
  localparam int L1 = 1, G1 = 1, S1 = 1;
  localparam logic [7:0] EOI = 8'h20;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  // ---------------- DUT signals ----------------
  logic       en0, req0, en1, req1;
  logic [7:0] din0, din1;
  logic       inta_n0, cs_n0, wr_n0, a0_0, data_oe0, vv0, ed0, busy0;
  logic [7:0] dout0, vec0;
  logic [2:0] st0;
  logic       inta_n1, cs_n1, wr_n1, a0_1, data_oe1, vv1, ed1, busy1;
  logic [7:0] dout1, vec1;
  logic [2:0] st1;

  pic_inta_master #(
    .INTA_LOW_CYCLES(L0), .INTA_GAP_CYCLES(G0), .SERVICE_CYCLES(S0), .EOI_CMD(EOI)
  ) dut0 (
    .clock(clock), .reset_n(reset_n), .enable(en0), .int_req(req0), .data_in(din0),
    .inta_n(inta_n0), .cs_n(cs_n0), .wr_n(wr_n0), .a0(a0_0), .data_out(dout0),
    .data_oe(data_oe0), .vector(vec0), .vector_valid(vv0), .eoi_done(ed0),
    .busy(busy0), .state_dbg(st0)
  );

  pic_inta_master #(
    .INTA_LOW_CYCLES(L1), .INTA_GAP_CYCLES(G1), .SERVICE_CYCLES(S1), .EOI_CMD(EOI)
  ) dut1 (
    .clock(clock), .reset_n(reset_n), .enable(en1), .int_req(req1), .data_in(din1),
    .inta_n(inta_n1), .cs_n(cs_n1), .wr_n(wr_n1), .a0(a0_1), .data_out(dout1),
    .data_oe(data_oe1), .vector(vec1), .vector_valid(vv1), .eoi_done(ed1),
    .busy(busy1), .state_dbg(st1)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int cycle    = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cycle, got, exp);
    else
      n_pass++;
  endtask

  // ---------------- reference model ----------------
  // k = 0 means idle; otherwise k is the cycle index after the sampling edge.
  int         k[2];
  logic [7:0] mvec[2];
  int         ml[2], mg[2], ms[2];
  logic [7:0] exp_q[$];

  task automatic model_edge(input int i, input logic en, input logic req, input logic [7:0] din);
    int cap, tot;
    cap = 2 * ml[i] + mg[i];
    tot = cap + ms[i] + 2;
    if (!reset_n) begin
      k[i]    = 0;
      mvec[i] = 8'h00;
    end else if (k[i] == 0) begin
      if (en && req) k[i] = 1;
    end else begin
      if (k[i] == cap) begin
        mvec[i] = din;
        if (i == 0) exp_q.push_back(din);
      end
      if (k[i] == tot) k[i] = 0;
      else k[i] = k[i] + 1;
    end
  endtask

  task automatic check_inst(input int i,
                            input logic inta_n, input logic cs_n, input logic wr_n,
                            input logic a0, input logic data_oe, input logic vv,
                            input logic ed, input logic busy,
                            input logic [7:0] dout, input logic [7:0] vec);
    int    kk, l, g, cap, eoi_cyc;
    logic  e_inta_low, e_eoi;
    string p;
    logic [7:0] expv;
    p       = (i == 0) ? "d0" : "d1";
    kk      = k[i];
    l       = ml[i];
    g       = mg[i];
    cap     = 2 * l + g;
    eoi_cyc = cap + ms[i] + 1;
    e_inta_low = ((kk >= 1) && (kk <= l)) || ((kk >= l + g + 1) && (kk <= cap));
    e_eoi      = (kk == eoi_cyc);
    check({p, "_inta_n"},   inta_n,  !e_inta_low);
    check({p, "_cs_n"},     cs_n,    !e_eoi);
    check({p, "_wr_n"},     wr_n,    !e_eoi);
    check({p, "_a0"},       a0,      1'b0);
    check({p, "_data_oe"},  data_oe, e_eoi);
    check({p, "_data_out"}, dout,    e_eoi ? EOI : 8'h00);
    check({p, "_vector"},   vec,     mvec[i]);
    check({p, "_vv"},       vv,      kk == cap + 1);
    check({p, "_eoi_done"}, ed,      kk == eoi_cyc + 1);
    check({p, "_busy"},     busy,    kk != 0);
    if (i == 0 && vv === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("d0_sb_unexpected_vv", 8'd1, 8'd0);
      end else begin
        expv = exp_q.pop_front();
        check("d0_sb_vector", vec, expv);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    model_edge(0, en0, req0, din0);
    model_edge(1, en1, req1, din1);
    #1;
    cycle++;
    check_inst(0, inta_n0, cs_n0, wr_n0, a0_0, data_oe0, vv0, ed0, busy0, dout0, vec0);
    check_inst(1, inta_n1, cs_n1, wr_n1, a0_1, data_oe1, vv1, ed1, busy1, dout1, vec1);
  endtask

  task automatic steps(input int n);
    for (int j = 0; j < n; j++) step();
  endtask

  // Called between edges: the strobes must rise without waiting for a clock.
  task automatic reset_pulse();
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_inta_n0", inta_n0, 1'b1);
    check("rst_cs_n0",   cs_n0,   1'b1);
    check("rst_wr_n0",   wr_n0,   1'b1);
    check("rst_busy0",   busy0,   1'b0);
    check("rst_inta_n1", inta_n1, 1'b1);
    check("rst_busy1",   busy1,   1'b0);
    for (int i = 0; i < 2; i++) begin
      k[i]    = 0;
      mvec[i] = 8'h00;
    end
    exp_q.delete();
    steps(2);
    reset_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    ml[0] = L0; mg[0] = G0; ms[0] = S0;
    ml[1] = L1; mg[1] = G1; ms[1] = S1;
    k[0] = 0; k[1] = 0;
    mvec[0] = 8'h00; mvec[1] = 8'h00;
    en0 = 1'b1; req0 = 1'b0; din0 = 8'h00;
    en1 = 1'b1; req1 = 1'b0; din1 = 8'h00;

    // Reset state
    steps(2);
    reset_n = 1'b1;
    steps(2);

    // Single sequence, vector 0B
    din0 = 8'h0B;
    req0 = 1'b1;
    step();
    req0 = 1'b0;
    steps(14);

    // int_req held across two sequences: 08 then 0F
    din0 = 8'h08;
    req0 = 1'b1;
    steps(10);
    din0 = 8'h0F;
    steps(16);
    req0 = 1'b0;
    steps(5);

    // enable low blocks the request, then raising enable starts it
    en0  = 1'b0;
    req0 = 1'b1;
    din0 = 8'h3C;
    steps(20);
    en0 = 1'b1;
    steps(13);
    req0 = 1'b0;
    steps(3);

    // Drop int_req and enable during GAP; the sequence must still complete
    din0 = 8'h21;
    req0 = 1'b1;
    step();
    steps(2);
    req0 = 1'b0;
    en0  = 1'b0;
    steps(14);
    en0 = 1'b1;

    // Reset in the middle of INTA2, then a full sequence
    din0 = 8'h77;
    req0 = 1'b1;
    steps(5);
    req0 = 1'b0;
    reset_pulse();
    steps(2);
    din0 = 8'h44;
    req0 = 1'b1;
    step();
    req0 = 1'b0;
    steps(14);

    // Minimum timing instance: data_in is 55 only during the INTA2 cycle
    din1 = 8'hAA;
    req1 = 1'b1;
    step();
    req1 = 1'b0;
    steps(2);
    din1 = 8'h55;
    step();
    din1 = 8'hAA;
    steps(5);

    // Randomized traffic on both instances with occasional async resets
    for (int n = 0; n < 800; n++) begin
      en0  = ($urandom_range(0, 9) != 0);
      req0 = ($urandom_range(0, 3) != 0);
      din0 = 8'($urandom_range(0, 255));
      en1  = ($urandom_range(0, 9) != 0);
      req1 = ($urandom_range(0, 2) != 0);
      din1 = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 199) == 0) reset_pulse();
      step();
    end
    req0 = 1'b0;
    req1 = 1'b0;
    steps(16);

    check("d0_sb_drained", 8'(exp_q.size()), 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pic_inta_master.md
# pic_inta_master

CPU-side interrupt acknowledge sequencer for the 8259 PIC project: the processor end of the INT/INTA protocol whose PIC end (IRR, IMR, ISR, priority) sets the in-service bit. The block sees INT from the PIC and runs the 8086-style two-pulse INTA cycle. It captures the interrupt vector the PIC drives on the data bus, waits a programmable service time, then writes a non-specific EOI (OCW2) back to the PIC to clear the in-service bit. It serves as the bus-functional master in PIC system benches and as the acknowledge front end of a minimal CPU model.

## Interface
- INTA_LOW_CYCLES, 2, clocks each INTA pulse is held low (≥1)
- INTA_GAP_CYCLES, 2, clocks inta_n is high between the two pulses (≥1)
- SERVICE_CYCLES, 4, clocks between vector capture and the EOI write (≥1)
- EOI_CMD, 8'h20, OCW2 byte written as EOI (non-specific EOI)
- clock  in  1  single system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  permits starting a new acknowledge sequence
- int_req  in  1  INT from PIC, same clock domain, active high
- data_in  in  8  PIC data bus, read during the second INTA pulse
- inta_n  out  1  interrupt acknowledge, active low
- cs_n  out  1  PIC chip select for the EOI write, active low
- wr_n  out  1  PIC write strobe, active low
- a0  out  1  PIC address line (0 for OCW2)
- data_out  out  8  write data to PIC
- data_oe  out  1  data_out bus drive enable
- vector  out  8  last captured vector, held until next capture
- vector_valid  out  1  one-cycle pulse, vector just updated
- eoi_done  out  1  one-cycle pulse, EOI write completed
- busy  out  1  high whenever state ≠ IDLE

## Operation
- States: IDLE → INTA1 → GAP → INTA2 → SERVICE → EOI_WR → EOI_REC → IDLE.
- IDLE: inta_n=1, cs_n=1, wr_n=1, data_oe=0. At a rising edge with enable=1 and int_req=1, go to INTA1.
- INTA1: inta_n=0 for INTA_LOW_CYCLES clocks. data_in is ignored.
- GAP: inta_n=1 for INTA_GAP_CYCLES clocks.
- INTA2: inta_n=0 for INTA_LOW_CYCLES clocks. On the edge that leaves INTA2, register data_in into vector. Values on data_in earlier in INTA2 are irrelevant.
- SERVICE: SERVICE_CYCLES clocks. vector_valid=1 in its first cycle only.
- EOI_WR: one clock with cs_n=0, wr_n=0, a0=0, data_out=EOI_CMD, data_oe=1.
- EOI_REC: one clock with cs_n=1, wr_n=1, data_oe=0, eoi_done=1, then IDLE.
- int_req and enable are sampled only in IDLE. A drop of either mid-sequence does not abort it; the sequence always completes, including the EOI.
- With int_req still high after EOI_REC, a new sequence starts from the first IDLE cycle. There is at least one IDLE cycle between sequences.
- One shared down-counter, width $clog2(max param)+1, loads N−1 on state entry and advances the state at zero.
- data_out is 8'h00 whenever data_oe=0. a0 is 0 at all times.

## Timing
- Reset values, applied asynchronously on reset_n=0: state=IDLE, inta_n=1, cs_n=1, wr_n=1, a0=0, data_out=0, data_oe=0, vector=0, vector_valid=0, eoi_done=0, busy=0.
- Reset mid-sequence: inta_n, cs_n and wr_n return high immediately without waiting for a clock edge. The sequence is abandoned and no EOI is issued.
- Let edge E be the IDLE edge that samples int_req=1. L, G and S are the parameters; cycle k is the k-th clock period after E.
- inta_n is low in cycles 1..L and high in cycles L+1..L+G.
- inta_n is low again in cycles L+G+1..2L+G. vector_valid is high in cycle 2L+G+1.
- The EOI write occurs in cycle 2L+G+S+1. eoi_done is high in cycle 2L+G+S+2. IDLE is entered at cycle 2L+G+S+3.
- With defaults: INTA low in cycles 1–2 and 5–6, vector_valid in cycle 7, EOI in cycle 11, eoi_done in cycle 12, 12 busy cycles.
- busy asserts in cycle 1, not in the sampling cycle.

## Test plan
- Default params. Raise int_req; PIC drives data_in=8'h0B in the last INTA2 cycle → inta_n low in cycles 1–2 and 5–6, vector=8'h0B with vector_valid in cycle 7, cs_n/wr_n low with data_out=8'h20 in cycle 11, eoi_done in cycle 12.
- Hold int_req high across two sequences with data_in 8'h08 then 8'h0F → two complete sequences, exactly one IDLE cycle between them, vector updates 08 → 0F.
- enable=0 with int_req=1 for 20 cycles → inta_n stays 1 and busy stays 0. Then raise enable → the sequence starts on the next edge.
- Drop int_req during GAP → the sequence still completes and the EOI is still written.
- Assert reset_n=0 in the middle of INTA2 → inta_n goes 1 immediately, vector stays 0, no vector_valid, no EOI. The next int_req runs a full sequence.
- Set INTA_LOW_CYCLES=1, INTA_GAP_CYCLES=1, SERVICE_CYCLES=1; change data_in from 8'hAA to 8'h55 only in the INTA2 cycle → vector=8'h55, EOI in cycle 5, eoi_done in cycle 6.
